gbt_link_pattern_checker: RTL and testbench

Parametrised GBT link test-pattern generator and checker. It sits between the application and the GBT core's user data (data_sent / data_received).
- The TX side drives a selectable pattern: off, lane counter, PRBS-31 or static.
- The RX side self-synchronises to the same pattern, tracks lock, and counts errors.
- Bitslip-reset gating is driven from SFP LOS and link_ready.
- It generalises the fixed 2x32-bit counter to any width, with modes, checking and lock tracking.

---
 rtl/gbt_test_pkg.sv | 39 +++
 rtl/gbt_pattern_gen.sv | 55 +++++
 rtl/gbt_link_pattern_checker.sv | 167 ++++++++++++++++
 tb/tb_gbt_link_pattern_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gbt_test_pkg.sv
// Shared types, constants and the PRBS-31 stepping function for the GBT
// link test-pattern generator/checker.
package gbt_test_pkg;

   typedef struct packed {
      logic clk;
      logic reset;
   } ckrs_t;

   typedef enum logic [1:0] {PM_OFF, PM_CNT, PM_PRBS, PM_STATIC} pattern_mode_t;
   typedef enum logic [1:0] {CHK_IDLE, CHK_SEEK, CHK_LOCKED} chk_state_t;

   localparam logic [30:0] PRBS_SEED = 31'h7FFFFFFF;

   // Widest frame the PRBS stepper can produce in one call.
   localparam int unsigned PRBS_MAX_W = 256;

   typedef struct packed {
      logic [30:0]           state;
      logic [PRBS_MAX_W-1:0] bits;
   } prbs_step_t;

   // x^31 + x^28 + 1, Fibonacci form. Each new bit enters the state LSB and
   // the output LSB, so the first bit produced ends up at bits[nbits-1].
   function automatic prbs_step_t prbs31_advance(input logic [30:0] state,
                                                 input int unsigned nbits);
      prbs_step_t r;
      logic       nb;
      r.state = state;
      r.bits  = '0;
      for (int unsigned i = 0; i < nbits; i++) begin
         nb      = r.state[30] ^ r.state[27];
         r.state = {r.state[29:0], nb};
         r.bits  = {r.bits[PRBS_MAX_W-2:0], nb};
      end
      return r;
   endfunction

endpackage

// File: rtl/gbt_pattern_gen.sv
// Pattern source: lane counter, PRBS-31 or static word. 'frame' is the value
// the next advance will produce; the state moves on advance, reseeds on load.
module gbt_pattern_gen
   import gbt_test_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 32
) (
   input  ckrs_t               ClkRs_ix,
   input  pattern_mode_t       mode,
   input  logic                clear,
   input  logic                load,
   input  logic                advance,
   input  logic [DATA_W-1:0]   seed,
   input  logic [DATA_W-1:0]   static_pattern,
   output logic [DATA_W-1:0]   frame
);

   localparam int unsigned N = DATA_W / CNT_W;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [30:0]      prbs;
   prbs_step_t       step;
   logic             unused_bits;

   assign unused_bits = ^{step.bits, seed};

   // Next frame for the selected mode.
   always_comb begin
      cnt_next = cnt + 1'b1;
      step     = prbs31_advance(prbs, DATA_W);
      case (mode)
         PM_CNT:    frame = {N{cnt_next}};
         PM_PRBS:   frame = step.bits[DATA_W-1:0];
         PM_STATIC: frame = static_pattern;
         default:   frame = '0;
      endcase
   end

   // Generator state: clear beats load beats advance.
   always_ff @(posedge ClkRs_ix.clk) begin
      if (!ClkRs_ix.reset || clear) begin
         cnt  <= '0;
         prbs <= PRBS_SEED;
      end else if (load) begin
         cnt  <= seed[CNT_W-1:0];
         prbs <= seed[30:0];
      end else if (advance) begin
         cnt  <= cnt_next;
         prbs <= step.state;
      end
   end

endmodule

// File: rtl/gbt_link_pattern_checker.sv
// GBT link test-pattern generator (TX) and self-synchronising checker (RX)
// with lock tracking, saturating error count and bitslip-reset gating.
module gbt_link_pattern_checker
   import gbt_test_pkg::*;
#(
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned ERR_W       = 16,
   parameter int unsigned LOCK_CYCLES = 8,
   parameter int unsigned UNLOCK_ERRS = 4
) (
   input  ckrs_t               ClkRs_ix,
   input  logic                los_i,
   input  logic                link_ready_i,
   input  logic [1:0]          mode_i,
   input  logic [DATA_W-1:0]   static_pattern_ib,
   input  logic                tx_valid_i,
   output logic [DATA_W-1:0]   tx_data_ob,
   output logic                bitslip_reset_o,
   input  logic                rx_valid_i,
   input  logic [DATA_W-1:0]   rx_data_ib,
   input  logic                clear_i,
   output logic                locked_o,
   output logic [1:0]          state_ob,
   output logic [ERR_W-1:0]    err_cnt_ob,
   output logic [31:0]         frame_cnt_ob
);

   localparam int unsigned RUN_W  = $clog2(LOCK_CYCLES + 1);
   localparam int unsigned MISS_W = $clog2(UNLOCK_ERRS + 1);

   pattern_mode_t     mode;
   pattern_mode_t     mode_q;
   chk_state_t        state;
   logic              link_ok;
   logic              abort;
   logic              have_seed;
   logic [RUN_W-1:0]  run;
   logic [MISS_W-1:0] miss;
   logic [DATA_W-1:0] tx_frame;
   logic [DATA_W-1:0] exp_frame;
   logic              match;
   logic              chk_load;
   logic              chk_adv;

   assign mode     = pattern_mode_t'(mode_i);
   assign link_ok  = link_ready_i & ~los_i;
   assign abort    = !link_ok || (mode == PM_OFF) || (mode != mode_q);
   assign match    = (rx_data_ib == exp_frame);
   assign locked_o = (state == CHK_LOCKED);
   assign state_ob = state;

   // Previous mode for change detection, and the bitslip-reset gate.
   always_ff @(posedge ClkRs_ix.clk) begin
      if (!ClkRs_ix.reset) begin
         mode_q          <= PM_OFF;
         bitslip_reset_o <= 1'b0;
      end else begin
         mode_q          <= mode;
         bitslip_reset_o <= link_ok;
      end
   end

   gbt_pattern_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_tx_gen (
      .ClkRs_ix       (ClkRs_ix),
      .mode           (mode),
      .clear          (abort),
      .load           (1'b0),
      .advance        (tx_valid_i & ~abort),
      .seed           ('0),
      .static_pattern (static_pattern_ib),
      .frame          (tx_frame)
   );

   // TX frame register: zero while the link or mode is not usable.
   always_ff @(posedge ClkRs_ix.clk) begin
      if (!ClkRs_ix.reset || abort) begin
         tx_data_ob <= '0;
      end else if (tx_valid_i) begin
         tx_data_ob <= tx_frame;
      end
   end

   // Expected-value control: reseed in SEEK, free-run in LOCKED.
   always_comb begin
      chk_load = 1'b0;
      chk_adv  = 1'b0;
      if (!abort && rx_valid_i) begin
         case (state)
            CHK_SEEK: begin
               if (!have_seed || !match) chk_load = 1'b1;
               else                      chk_adv  = 1'b1;
            end
            CHK_LOCKED: chk_adv = 1'b1;
            default: ;
         endcase
      end
   end

   gbt_pattern_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_exp_gen (
      .ClkRs_ix       (ClkRs_ix),
      .mode           (mode),
      .clear          (abort || (state == CHK_IDLE)),
      .load           (chk_load),
      .advance        (chk_adv),
      .seed           (rx_data_ib),
      .static_pattern (static_pattern_ib),
      .frame          (exp_frame)
   );

   // Checker FSM; loss of link or a mode change drops to IDLE at once.
   always_ff @(posedge ClkRs_ix.clk) begin
      if (!ClkRs_ix.reset) begin
         state     <= CHK_IDLE;
         have_seed <= 1'b0;
         run       <= '0;
         miss      <= '0;
      end else if (abort) begin
         state <= CHK_IDLE;
      end else if (rx_valid_i) begin
         case (state)
            CHK_IDLE: begin
               state     <= CHK_SEEK;
               have_seed <= 1'b0;
               run       <= '0;
               miss      <= '0;
            end
            CHK_SEEK: begin
               if (!have_seed || !match) begin
                  have_seed <= 1'b1;
                  run       <= '0;
               end else if (run == RUN_W'(LOCK_CYCLES - 1)) begin
                  state <= CHK_LOCKED;
                  miss  <= '0;
               end else begin
                  run <= run + 1'b1;
               end
            end
            CHK_LOCKED: begin
               if (match) begin
                  miss <= '0;
               end else if (miss == MISS_W'(UNLOCK_ERRS - 1)) begin
                  state     <= CHK_SEEK;
                  have_seed <= 1'b0;
                  run       <= '0;
                  miss      <= '0;
               end else begin
                  miss <= miss + 1'b1;
               end
            end
            default: state <= CHK_IDLE;
         endcase
      end
   end

   // Frame and error counters, counted only while LOCKED; clear wins.
   always_ff @(posedge ClkRs_ix.clk) begin
      if (!ClkRs_ix.reset || clear_i) begin
         err_cnt_ob   <= '0;
         frame_cnt_ob <= '0;
      end else if (rx_valid_i && !abort && state == CHK_LOCKED) begin
         frame_cnt_ob <= frame_cnt_ob + 32'd1;
         if (!match && err_cnt_ob != '1) err_cnt_ob <= err_cnt_ob + 1'b1;
      end
   end

endmodule

// File: tb/tb_gbt_link_pattern_checker.sv
// Directed loopback bench for gbt_link_pattern_checker: DUT a uses defaults,
// DUT b uses CNT_W=8 / ERR_W=4 and sees the same stimulus.
module tb_gbt_link_pattern_checker;
   import gbt_test_pkg::*;

   localparam logic [63:0] STATIC_PAT = 64'hDEADBEEF_CAFEF00D;
   localparam logic [63:0] FLIP       = 64'h0000_0000_0000_0020;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   ckrs_t       ckrs;
   logic        los = 1'b0;
   logic        link_ready = 1'b1;
   logic [1:0]  mode = 2'd1;
   logic        tx_valid = 1'b0;
   logic        rx_valid = 1'b0;
   logic        clear = 1'b0;
   logic [63:0] rx_a = '0;
   logic [63:0] rx_b = '0;

   logic [63:0] tx_a, tx_b;
   logic        bs_a, bs_b, locked_a, locked_b;
   logic [1:0]  state_a, state_b;
   logic [15:0] err_a;
   logic [3:0]  err_b;
   logic [31:0] frame_a, frame_b;

   int          tests = 0;
   int          fails = 0;

   logic [31:0]  m_cnt;
   logic [30:0]  m_prbs;
   logic [127:0] sb[$];

   assign ckrs = {clk, rst_n};
   always #5 clk = ~clk;

   gbt_link_pattern_checker dut_a (
      .ClkRs_ix(ckrs), .los_i(los), .link_ready_i(link_ready), .mode_i(mode),
      .static_pattern_ib(STATIC_PAT), .tx_valid_i(tx_valid), .tx_data_ob(tx_a),
      .bitslip_reset_o(bs_a), .rx_valid_i(rx_valid), .rx_data_ib(rx_a),
      .clear_i(clear), .locked_o(locked_a), .state_ob(state_a),
      .err_cnt_ob(err_a), .frame_cnt_ob(frame_a));

   gbt_link_pattern_checker #(.CNT_W(8), .ERR_W(4)) dut_b (
      .ClkRs_ix(ckrs), .los_i(los), .link_ready_i(link_ready), .mode_i(mode),
      .static_pattern_ib(STATIC_PAT), .tx_valid_i(tx_valid), .tx_data_ob(tx_b),
      .bitslip_reset_o(bs_b), .rx_valid_i(rx_valid), .rx_data_ib(rx_b),
      .clear_i(clear), .locked_o(locked_b), .state_ob(state_b),
      .err_cnt_ob(err_b), .frame_cnt_ob(frame_b));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt  = '0;
      m_prbs = PRBS_SEED;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One TX frame, then loop it back (optionally corrupted) as one RX frame.
   task automatic send(input logic [63:0] flip, input logic clr);
      logic [63:0]  ea, eb, f;
      logic [127:0] e;
      logic         nb;
      @(negedge clk);
      tx_valid = 1'b1;
      case (mode)
         2'd1: begin
            m_cnt = m_cnt + 32'd1;
            ea = {2{m_cnt}};
            eb = {8{m_cnt[7:0]}};
         end
         2'd2: begin
            f = '0;
            for (int i = 0; i < 64; i++) begin
               nb     = m_prbs[30] ^ m_prbs[27];
               m_prbs = {m_prbs[29:0], nb};
               f      = {f[62:0], nb};
            end
            ea = f;
            eb = f;
         end
         default: begin
            ea = STATIC_PAT;
            eb = STATIC_PAT;
         end
      endcase
      sb.push_back({ea, eb});
      @(negedge clk);
      tx_valid = 1'b0;
      e = sb.pop_front();
      chk("tx_a", tx_a, e[127:64]);
      chk("tx_b", tx_b, e[63:0]);
      rx_valid = 1'b1;
      rx_a     = tx_a ^ flip;
      rx_b     = tx_b ^ flip;
      clear    = clr;
      @(negedge clk);
      rx_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic chk_state(input string tag, input logic [1:0] exp);
      chk({tag, "_a"}, 64'(state_a), 64'(exp));
      chk({tag, "_b"}, 64'(state_b), 64'(exp));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      // Reset state
      wait_cyc(3);
      chk("rst_tx", tx_a, 64'h0);
      chk("rst_bs", 64'(bs_a), 64'h0);
      chk("rst_state", 64'(state_a), 64'h0);
      chk("rst_locked", 64'(locked_a), 64'h0);
      chk("rst_err", 64'(err_a), 64'h0);
      chk("rst_frame", 64'(frame_a), 64'h0);
      rst_n = 1'b1;
      wait_cyc(2);
      chk("bs_up", 64'(bs_a), 64'h1);

      // Counter mode: first three frames
      send('0, 1'b0);
      chk("cnt_f1", tx_a, 64'h00000001_00000001);
      send('0, 1'b0);
      chk("cnt_f2", tx_a, 64'h00000002_00000002);
      send('0, 1'b0);
      chk("cnt_f3", tx_a, 64'h00000003_00000003);

      // PRBS loopback: IDLE frame, seed frame, then 8 matches to lock
      mode = 2'd2;
      model_reset();
      wait_cyc(2);
      chk_state("prbs_idle", 2'd0);
      send('0, 1'b0);
      chk_state("prbs_seek1", 2'd1);
      for (int i = 0; i < 8; i++) send('0, 1'b0);
      chk_state("prbs_seek9", 2'd1);
      send('0, 1'b0);
      chk_state("prbs_locked", 2'd2);
      chk("prbs_locked_o", 64'(locked_a), 64'h1);
      chk("prbs_frame0", 64'(frame_a), 64'h0);
      send('0, 1'b0);
      send('0, 1'b0);
      chk("prbs_frame2", 64'(frame_a), 64'd2);
      chk("prbs_err0", 64'(err_a), 64'h0);

      // Three isolated errors keep lock; four in a row drop to SEEK
      for (int i = 0; i < 3; i++) begin
         send(FLIP, 1'b0);
         send('0, 1'b0);
      end
      chk("err3_a", 64'(err_a), 64'd3);
      chk_state("err3_state", 2'd2);
      for (int i = 0; i < 4; i++) send(FLIP, 1'b0);
      chk("err7_a", 64'(err_a), 64'd7);
      chk("err7_b", 64'(err_b), 64'd7);
      chk("frame12", 64'(frame_a), 64'd12);
      chk_state("unlock_seek", 2'd1);
      for (int i = 0; i < 9; i++) send('0, 1'b0);
      chk_state("relock", 2'd2);

      // Loss of signal while LOCKED
      @(negedge clk);
      los = 1'b1;
      @(negedge clk);
      chk_state("los_idle", 2'd0);
      chk("los_tx", tx_a, 64'h0);
      chk("los_bs", 64'(bs_a), 64'h0);
      chk("los_locked", 64'(locked_a), 64'h0);
      los = 1'b0;
      model_reset();
      wait_cyc(2);
      for (int i = 0; i < 10; i++) send('0, 1'b0);
      chk_state("los_relock", 2'd2);
      chk("los_keep_err", 64'(err_a), 64'd7);
      chk("los_keep_frame", 64'(frame_a), 64'd12);

      // Clear coincident with an error
      send(FLIP, 1'b1);
      chk("clr_err_a", 64'(err_a), 64'h0);
      chk("clr_err_b", 64'(err_b), 64'h0);
      chk("clr_frame", 64'(frame_a), 64'h0);
      send('0, 1'b0);
      chk("clr_frame1", 64'(frame_a), 64'd1);

      // Mode change 1 -> 3 while LOCKED
      mode = 2'd1;
      model_reset();
      wait_cyc(2);
      for (int i = 0; i < 10; i++) send('0, 1'b0);
      chk_state("cnt_locked", 2'd2);
      @(negedge clk);
      mode = 2'd3;
      model_reset();
      @(negedge clk);
      chk_state("m3_idle", 2'd0);
      send('0, 1'b0);
      chk_state("m3_seek", 2'd1);
      chk("m3_tx", tx_a, STATIC_PAT);
      for (int i = 0; i < 9; i++) send('0, 1'b0);
      chk_state("m3_locked", 2'd2);

      // 8-bit lane counter wrap on dut_b
      mode = 2'd1;
      model_reset();
      wait_cyc(2);
      while (m_cnt != 32'd254) send('0, 1'b0);
      send('0, 1'b0);
      chk("wrap_ff", tx_b, {8{8'hFF}});
      send('0, 1'b0);
      chk("wrap_00", tx_b, 64'h0);
      chk_state("wrap_locked", 2'd2);
      chk("wrap_err_b", 64'(err_b), 64'h0);
      chk("wrap_frame", 64'(frame_a), 64'd247);

      // 20 isolated errors: dut_b saturates at 15
      for (int i = 0; i < 20; i++) begin
         send(FLIP, 1'b0);
         send('0, 1'b0);
      end
      chk("sat_err_b", 64'(err_b), 64'd15);
      chk("sat_err_a", 64'(err_a), 64'd20);
      chk_state("sat_locked", 2'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
